// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter: recovers the divide ratio of a divided clock
// by counting system-clock cycles between its rising edges.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module clk_ratio_meter #(
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clk_in,
  output logic [DATA_WIDTH-1:0] ratio_out,
  output logic                  ratio_valid,
  output logic                  stable,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [DATA_WIDTH-1:0] CNT_ONE = 1;

  state_t                state;
  logic [DATA_WIDTH-1:0] cnt;
  logic                  clk_in_q;
  logic                  have_prev;
  logic                  rise;

  assign rise = clk_in & ~clk_in_q;

  // Delayed copy of clk_in, tracked in every state for edge detection.
  always_ff @(posedge clk) begin
    if (reset) clk_in_q <= 1'b0;
    else       clk_in_q <= clk_in;
  end

  // Measurement FSM: arm on a rise, count to the next rise, report.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      have_prev   <= 1'b0;
      ratio_out   <= '0;
      ratio_valid <= 1'b0;
      stable      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      ratio_valid <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        cnt       <= '0;
        have_prev <= 1'b0;
        stable    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
          end
          ARM: begin
            have_prev <= 1'b0;
            if (rise) begin
              cnt   <= CNT_ONE;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              ratio_out   <= cnt;
              ratio_valid <= 1'b1;
              overflow    <= 1'b0;
              stable      <= have_prev && (cnt == ratio_out);
              have_prev   <= 1'b1;
              cnt         <= CNT_ONE;
            end else if (cnt == CNT_MAX) begin
              overflow <= 1'b1;
              stable   <= 1'b0;
              cnt      <= '0;
              state    <= ARM;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// tb_clk_ratio_meter: directed checks of ratio recovery,
// stability, overflow, enable drop and reset behaviour.
module tb_clk_ratio_meter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       clk_in = 1'b0;
  logic [7:0] ratio_out;
  logic       ratio_valid;
  logic       stable;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int extra = 0;
  int v, r, s;

  clk_ratio_meter #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clk_in     (clk_in),
    .ratio_out  (ratio_out),
    .ratio_valid(ratio_valid),
    .stable     (stable),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic ci);
    clk_in = ci;
    @(posedge clk);
    #1;
  endtask

  // One clk_in period of p cycles, starting with its rising edge.
  // Reports outputs right after the rise; counts stray valids.
  task automatic per(input int p, output int pv, output int pr, output int ps);
    tick(1'b1);
    pv = int'(ratio_valid);
    pr = int'(ratio_out);
    ps = int'(stable);
    for (int i = 1; i < p; i++) begin
      tick(i < p / 2);
      if (ratio_valid) extra++;
    end
  endtask

  initial begin
    tick(1'b0);
    tick(1'b0);
    chk("rst_ratio", int'(ratio_out), 0);
    chk("rst_valid", int'(ratio_valid), 0);
    chk("rst_stable", int'(stable), 0);
    chk("rst_ovf", int'(overflow), 0);

    reset = 1'b0;
    enable = 1'b1;
    tick(1'b0);
    per(4, v, r, s);
    chk("p4_arm_v", v, 0);
    per(4, v, r, s);
    chk("p4_1_v", v, 1);
    chk("p4_1_r", r, 4);
    chk("p4_1_s", s, 0);
    per(4, v, r, s);
    chk("p4_2_r", r, 4);
    chk("p4_2_s", s, 1);
    per(4, v, r, s);
    chk("p4_3_v", v, 1);
    chk("p4_3_s", s, 1);
    chk("p4_extra", extra, 0);

    per(10, v, r, s);
    chk("sw_last4", r, 4);
    per(10, v, r, s);
    chk("p10_1_r", r, 10);
    chk("p10_1_s", s, 0);
    per(10, v, r, s);
    chk("p10_2_r", r, 10);
    chk("p10_2_s", s, 1);

    per(6, v, r, s);
    per(6, v, r, s);
    chk("p6_r", r, 6);
    tick(1'b1);
    chk("hold_rise_r", int'(ratio_out), 6);
    chk("hold_rise_s", int'(stable), 1);
    for (int i = 1; i < 300; i++) begin
      tick(1'b1);
      if (ratio_valid) extra++;
      if (i == 254) chk("ovf_at254", int'(overflow), 0);
      if (i == 255) chk("ovf_at255", int'(overflow), 1);
    end
    chk("hold_ovf", int'(overflow), 1);
    chk("hold_s", int'(stable), 0);
    chk("hold_r", int'(ratio_out), 6);
    chk("hold_extra", extra, 0);
    tick(1'b0);
    per(8, v, r, s);
    chk("p8_rearm_v", v, 0);
    per(8, v, r, s);
    chk("p8_v", v, 1);
    chk("p8_r", r, 8);
    chk("p8_ovf", int'(overflow), 0);
    chk("p8_s", s, 0);

    per(255, v, r, s);
    per(255, v, r, s);
    chk("p255_v", v, 1);
    chk("p255_r", r, 255);
    chk("p255_ovf", int'(overflow), 0);
    per(256, v, r, s);
    chk("p256_prev_r", r, 255);
    chk("p256_ovf", int'(overflow), 1);
    chk("p256_extra", extra, 0);
    per(4, v, r, s);
    chk("p256_next_v", v, 0);
    chk("ovf_sticky", int'(overflow), 1);
    per(4, v, r, s);
    chk("ovf_clr_v", v, 1);
    chk("ovf_clr_r", r, 4);
    chk("ovf_clr", int'(overflow), 0);

    per(4, v, r, s);
    chk("pre_drop_s", s, 1);
    enable = 1'b0;
    tick(1'b1);
    chk("drop_v", int'(ratio_valid), 0);
    chk("drop_s", int'(stable), 0);
    chk("drop_r", int'(ratio_out), 4);
    tick(1'b1);
    enable = 1'b1;
    tick(1'b1);
    tick(1'b1);
    chk("en_high_v", int'(ratio_valid), 0);
    tick(1'b0);
    tick(1'b0);
    per(4, v, r, s);
    chk("reen_arm_v", v, 0);
    per(4, v, r, s);
    chk("reen_v", v, 1);
    chk("reen_r", r, 4);
    chk("reen_s", s, 0);

    per(4, v, r, s);
    tick(1'b1);
    tick(1'b0);
    reset = 1'b1;
    tick(1'b0);
    chk("mid_rst_r", int'(ratio_out), 0);
    chk("mid_rst_v", int'(ratio_valid), 0);
    chk("mid_rst_s", int'(stable), 0);
    chk("mid_rst_o", int'(overflow), 0);
    reset = 1'b0;
    tick(1'b0);
    per(4, v, r, s);
    chk("post_rst_arm", v, 0);
    per(4, v, r, s);
    chk("post_rst_v", v, 1);
    chk("post_rst_r", r, 4);
    chk("final_extra", extra, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_ratio_meter.md
# clk_ratio_meter

- Measures the period of a divided clock, in cycles of the system clock, and reports it as a ratio word.
- It is the receive-side counterpart of the programmable clock divider: the divider turns a ratio into a clock; this block recovers the ratio from the clock.
- It sits beside the divider on the same `clk` domain and is used for self-check and status readback.
- `clk_in` is treated as a synchronous data input, not as a clock.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (8): width of the ratio word and of the period counter.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  measurement enable; low forces IDLE.
- `clk_in`  in  1  divided clock under measurement, synchronous to `clk`.
- `ratio_out`  out  DATA_WIDTH  last valid period, in `clk` cycles.
- `ratio_valid`  out  1  one-cycle pulse when `ratio_out` is updated.
- `stable`  out  1  high while the last two valid measurements are equal.
- `overflow`  out  1  sticky; set when a period exceeds 2^DATA_WIDTH-1.

## Operation
- `clk_in_q` registers `clk_in` every cycle in every state, including IDLE.
- `rise = clk_in & ~clk_in_q` is combinational.
- `cnt` is a DATA_WIDTH-bit counter.
- States and transitions:
  - IDLE: `cnt` = 0. Go to ARM when `enable` = 1.
  - ARM: wait for `rise`. On `rise`: `cnt` <= 1, go to MEASURE. No output update.
  - MEASURE, `rise` = 1: `ratio_out` <= `cnt`, `ratio_valid` <= 1, `overflow` <= 0, `stable` <= (`cnt` == previous `ratio_out`) and a previous valid exists since the last arm; `cnt` <= 1.
  - MEASURE, `rise` = 0 and `cnt` == 2^DATA_WIDTH-1: `overflow` <= 1, `stable` <= 0, `cnt` <= 0, go to ARM. No `ratio_valid`.
  - MEASURE, otherwise: `cnt` <= `cnt` + 1.
- `enable` = 0 in any state: go to IDLE at the next edge. This takes priority over `rise` and over the overflow check, so no `ratio_valid` is issued on that edge.
- `ratio_out` and `overflow` keep their values while in IDLE.
- `stable` is cleared on entry to IDLE.
- The "previous valid" history is cleared on every arm, so the first measurement after ARM never sets `stable`.
- Measurable range is 2 to 2^DATA_WIDTH-1. A period of exactly 2^DATA_WIDTH-1 is valid; one cycle more is an overflow.

## Timing
- Reset values: `ratio_out` = 0, `ratio_valid` = 0, `stable` = 0, `overflow` = 0, `cnt` = 0, `clk_in_q` = 0, state = IDLE.
- Latency: if `rise` is true at edge t, then `ratio_out`, `ratio_valid` and `stable` are visible after edge t. `ratio_valid` deasserts after edge t+1.
- For rises at edges t0 and t0+P, the second rise reports `ratio_out` = P.
- With a continuous `clk_in` of period P, `ratio_valid` pulses every P cycles.
- Enabling while `clk_in` is already high produces no false edge, because `clk_in_q` tracks `clk_in` in IDLE.
- `reset` mid-measurement returns every output to its reset value at that edge. No `ratio_valid` is emitted.
- `overflow` is set at the edge where `cnt` = 2^DATA_WIDTH-1 with no rise. It clears only on the next `ratio_valid` or on `reset`.

## Test plan
- DATA_WIDTH = 8; `clk_in` period 4 (2 high, 2 low); `enable` = 1 → first `ratio_valid` on the 2nd rise with `ratio_out` = 4. `stable` = 1 from the 3rd rise. Pulses repeat every 4 cycles.
- Period switched from 4 to 10 → first new pulse gives `ratio_out` = 10 and `stable` = 0; the next pulse gives `ratio_out` = 10 and `stable` = 1.
- `clk_in` held high for 300 cycles after a valid measurement of 6 → `overflow` = 1 at `cnt` 255, `stable` = 0, `ratio_out` stays 6. After `clk_in` resumes with period 8: the first rise re-arms, the second rise gives `ratio_out` = 8 and `overflow` = 0.
- Period exactly 255 → `ratio_out` = 255, `overflow` = 0. Period 256 → `overflow` = 1 and no `ratio_valid`.
- `enable` dropped on the same edge as a rise → no `ratio_valid`, state IDLE, `stable` = 0. After re-enable, the first `ratio_valid` comes on the 2nd rise.
- `reset` asserted mid-MEASURE with `ratio_out` = 4 → after that edge all outputs are 0. With `reset` released and `enable` high, the next valid measurement arrives on the 2nd subsequent rise.
